matvec_sequencer: RTL and testbench

- Control FSM for the matrix-vector accelerator datapath.
- Takes a start command and dimensions from the general CSR. Issues read addresses to the vector and matrix buffers, drives the MAC enable/first/last strobes, and hands each finished row result to the readout path over a valid/ready handshake.
- Sits between the CSR block and the MAC/buffer datapath. It owns the sequencing only and never touches data words.

---
 rtl/matvec_sequencer.sv | 162 ++++++++++++++++
 tb/tb_matvec_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_sequencer.sv
// Sequencing FSM for the matrix-vector accelerator: issues buffer reads, MAC strobes
// and per-row result handshakes. It never touches data words.
module matvec_sequencer #(
  parameter int DIM_W  = 8,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DIM_W-1:0]  rows,
  input  logic [DIM_W-1:0]  cols,
  output logic              vec_rd_en,
  output logic [ADDR_W-1:0] vec_rd_addr,
  output logic              mat_rd_en,
  output logic [ADDR_W-1:0] mat_rd_addr,
  output logic              mac_en,
  output logic              mac_first,
  output logic              mac_last,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DIM_W-1:0]  res_row,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESULT} state_t;

  localparam int CMP_W = (2 * DIM_W > ADDR_W + 1) ? 2 * DIM_W : ADDR_W + 1;

  state_t state, state_next;

  logic [DIM_W-1:0]  rows_q, cols_q, r, c;
  logic [ADDR_W-1:0] base;
  logic [2:0]        drain_cnt;
  logic [RD_LAT-1:0] pipe_en, pipe_first, pipe_last;
  logic [CMP_W-1:0]  prod;
  logic              bad_dims, last_col, last_row, drain_done;
  logic              accept, reject, issue, row_adv, finish, flush;

  // The product only guards against a matrix larger than the buffer; addressing uses base.
  assign prod       = CMP_W'(rows) * CMP_W'(cols);
  assign bad_dims   = (rows == '0) || (cols == '0) || (prod > (CMP_W'(1) << ADDR_W));
  assign last_col   = (c == cols_q - DIM_W'(1));
  assign last_row   = (r == rows_q - DIM_W'(1));
  assign drain_done = (drain_cnt == 3'(RD_LAT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    reject     = 1'b0;
    issue      = 1'b0;
    row_adv    = 1'b0;
    finish     = 1'b0;
    flush      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (bad_dims) begin
            reject = 1'b1;
          end else begin
            accept     = 1'b1;
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        issue = 1'b1;
        if (last_col) state_next = DRAIN;
      end
      DRAIN: begin
        if (drain_done) state_next = RESULT;
      end
      RESULT: begin
        if (res_ready) begin
          if (last_row) begin
            finish     = 1'b1;
            state_next = IDLE;
          end else begin
            row_adv    = 1'b1;
            state_next = ISSUE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // Abort overrides whatever the current state decided, including a pending done.
    if (abort && state != IDLE) begin
      flush      = 1'b1;
      finish     = 1'b0;
      row_adv    = 1'b0;
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q     <= '0;
      cols_q     <= '0;
      r          <= '0;
      c          <= '0;
      base       <= '0;
      drain_cnt  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      pipe_en    <= '0;
      pipe_first <= '0;
      pipe_last  <= '0;
    end else begin
      done <= finish;
      err  <= reject;
      if (accept) begin
        rows_q <= rows;
        cols_q <= cols;
        r      <= '0;
        c      <= '0;
        base   <= '0;
      end else if (row_adv) begin
        r    <= r + DIM_W'(1);
        c    <= '0;
        base <= base + ADDR_W'(cols_q);
      end else if (issue && !last_col) begin
        c <= c + DIM_W'(1);
      end
      if (state == DRAIN) drain_cnt <= drain_cnt + 3'd1;
      else                drain_cnt <= '0;
      if (flush) begin
        pipe_en    <= '0;
        pipe_first <= '0;
        pipe_last  <= '0;
      end else begin
        for (int i = RD_LAT - 1; i > 0; i--) begin
          pipe_en[i]    <= pipe_en[i-1];
          pipe_first[i] <= pipe_first[i-1];
          pipe_last[i]  <= pipe_last[i-1];
        end
        pipe_en[0]    <= issue;
        pipe_first[0] <= issue && (c == '0);
        pipe_last[0]  <= issue && last_col;
      end
    end
  end

  assign vec_rd_en   = issue;
  assign mat_rd_en   = issue;
  assign vec_rd_addr = issue ? ADDR_W'(c) : '0;
  assign mat_rd_addr = issue ? base + ADDR_W'(c) : '0;
  assign mac_en      = pipe_en[RD_LAT-1];
  assign mac_first   = pipe_first[RD_LAT-1];
  assign mac_last    = pipe_last[RD_LAT-1];
  assign res_valid   = (state == RESULT);
  assign res_row     = (state == RESULT) ? r : '0;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_matvec_sequencer.sv
// Directed bench for matvec_sequencer: instance a (ADDR_W=10, RD_LAT=1) and
// instance b (ADDR_W=4, RD_LAT=3) checked cycle by cycle against hand-written tables.
module tb_matvec_sequencer;

  logic clk;
  logic rst_n;

  logic       a_start, a_abort, a_ready;
  logic [7:0] a_rows, a_cols;
  logic       a_vec_rd_en, a_mat_rd_en, a_mac_en, a_mac_first, a_mac_last;
  logic       a_res_valid, a_busy, a_done, a_err;
  logic [9:0] a_vec_rd_addr, a_mat_rd_addr;
  logic [7:0] a_res_row;

  logic       b_start, b_abort, b_ready;
  logic [7:0] b_rows, b_cols;
  logic       b_vec_rd_en, b_mat_rd_en, b_mac_en, b_mac_first, b_mac_last;
  logic       b_res_valid, b_busy, b_done, b_err;
  logic [3:0] b_vec_rd_addr, b_mat_rd_addr;
  logic [7:0] b_res_row;

  int n_checks;
  int n_fails;

  // Flag bundles: {vec_rd_en, mat_rd_en, mac_en, mac_first, mac_last, res_valid, done, busy, err}
  wire [8:0] a_flags = {a_vec_rd_en, a_mat_rd_en, a_mac_en, a_mac_first, a_mac_last,
                        a_res_valid, a_done, a_busy, a_err};
  wire [8:0] b_flags = {b_vec_rd_en, b_mat_rd_en, b_mac_en, b_mac_first, b_mac_last,
                        b_res_valid, b_done, b_busy, b_err};

  logic [8:0] exp_basic [1:12];
  int         exp_vec   [1:12];
  int         exp_mat   [1:12];
  logic [8:0] exp_lat   [1:6];

  matvec_sequencer #(.DIM_W(8), .ADDR_W(10), .RD_LAT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort),
    .rows(a_rows), .cols(a_cols),
    .vec_rd_en(a_vec_rd_en), .vec_rd_addr(a_vec_rd_addr),
    .mat_rd_en(a_mat_rd_en), .mat_rd_addr(a_mat_rd_addr),
    .mac_en(a_mac_en), .mac_first(a_mac_first), .mac_last(a_mac_last),
    .res_valid(a_res_valid), .res_ready(a_ready), .res_row(a_res_row),
    .busy(a_busy), .done(a_done), .err(a_err)
  );

  matvec_sequencer #(.DIM_W(8), .ADDR_W(4), .RD_LAT(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
    .rows(b_rows), .cols(b_cols),
    .vec_rd_en(b_vec_rd_en), .vec_rd_addr(b_vec_rd_addr),
    .mat_rd_en(b_mat_rd_en), .mat_rd_addr(b_mat_rd_addr),
    .mac_en(b_mac_en), .mac_first(b_mac_first), .mac_last(b_mac_last),
    .res_valid(b_res_valid), .res_ready(b_ready), .res_row(b_res_row),
    .busy(b_busy), .done(b_done), .err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_start = 0; a_abort = 0; a_ready = 0; a_rows = 0; a_cols = 0;
    b_start = 0; b_abort = 0; b_ready = 0; b_rows = 0; b_cols = 0;
    #12;
    n_checks++;
    if (a_flags !== 9'b0 || a_vec_rd_addr !== 10'd0 || a_mat_rd_addr !== 10'd0 || a_res_row !== 8'd0) begin
      n_fails++;
      $display("[TB] FAIL reset_a flags=%b vec=%0d mat=%0d row=%0d expected all 0",
               a_flags, a_vec_rd_addr, a_mat_rd_addr, a_res_row);
    end
    n_checks++;
    if (b_flags !== 9'b0 || b_vec_rd_addr !== 4'd0 || b_mat_rd_addr !== 4'd0) begin
      n_fails++;
      $display("[TB] FAIL reset_b flags=%b vec=%0d mat=%0d expected all 0",
               b_flags, b_vec_rd_addr, b_mat_rd_addr);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    exp_basic = '{9'b11_000_0010, 9'b11_110_0010, 9'b11_100_0010, 9'b00_101_0010,
                  9'b00_000_1010, 9'b11_000_0010, 9'b11_110_0010, 9'b11_100_0010,
                  9'b00_101_0010, 9'b00_000_1010, 9'b00_000_0100, 9'b00_000_0000};
    exp_vec = '{0, 1, 2, 0, 0, 0, 1, 2, 0, 0, 0, 0};
    exp_mat = '{0, 1, 2, 0, 0, 3, 4, 5, 0, 0, 0, 0};
    a_rows = 2; a_cols = 3; a_ready = 1; a_start = 1;
    tick();
    a_start = 0;
    for (int k = 1; k <= 12; k++) begin
      n_checks++;
      if (a_flags !== exp_basic[k]) begin
        n_fails++;
        $display("[TB] FAIL basic_flags cycle %0d got %b expected %b", k, a_flags, exp_basic[k]);
      end
      if (exp_basic[k][8]) begin
        n_checks++;
        if (a_vec_rd_addr !== 10'(exp_vec[k]) || a_mat_rd_addr !== 10'(exp_mat[k])) begin
          n_fails++;
          $display("[TB] FAIL basic_addr cycle %0d got vec=%0d mat=%0d expected vec=%0d mat=%0d",
                   k, a_vec_rd_addr, a_mat_rd_addr, exp_vec[k], exp_mat[k]);
        end
      end
      if (exp_basic[k][3]) begin
        n_checks++;
        if (a_res_row !== ((k == 5) ? 8'd0 : 8'd1)) begin
          n_fails++;
          $display("[TB] FAIL basic_row cycle %0d got %0d expected %0d", k, a_res_row, (k == 5) ? 0 : 1);
        end
      end
      tick();
    end
    a_ready = 0;
  endtask

  task automatic test_backpressure();
    a_rows = 2; a_cols = 2; a_ready = 0; a_start = 1;
    tick();
    a_start = 0;
    tick(); tick(); tick();
    for (int k = 4; k <= 9; k++) begin
      n_checks++;
      if (a_flags !== 9'b00_000_1010 || a_res_row !== 8'd0) begin
        n_fails++;
        $display("[TB] FAIL stall cycle %0d got flags=%b row=%0d expected flags=000001010 row=0",
                 k, a_flags, a_res_row);
      end
      tick();
    end
    a_ready = 1;
    tick();
    n_checks++;
    if (a_flags !== 9'b11_000_0010 || a_mat_rd_addr !== 10'd2 || a_vec_rd_addr !== 10'd0) begin
      n_fails++;
      $display("[TB] FAIL release_row1 got flags=%b mat=%0d vec=%0d expected 110000010 mat=2 vec=0",
               a_flags, a_mat_rd_addr, a_vec_rd_addr);
    end
    tick();
    n_checks++;
    if (a_flags !== 9'b11_110_0010 || a_mat_rd_addr !== 10'd3 || a_vec_rd_addr !== 10'd1) begin
      n_fails++;
      $display("[TB] FAIL row1_second got flags=%b mat=%0d vec=%0d expected 111100010 mat=3 vec=1",
               a_flags, a_mat_rd_addr, a_vec_rd_addr);
    end
    tick(); tick();
    n_checks++;
    if (a_flags !== 9'b00_000_1010 || a_res_row !== 8'd1) begin
      n_fails++;
      $display("[TB] FAIL bp_result1 got flags=%b row=%0d expected 000001010 row=1", a_flags, a_res_row);
    end
    tick();
    n_checks++;
    if (a_flags !== 9'b00_000_0100) begin
      n_fails++;
      $display("[TB] FAIL bp_done got %b expected 000000100", a_flags);
    end
    a_ready = 0;
    tick();
  endtask

  task automatic test_reject();
    b_rows = 3; b_cols = 0; b_start = 1;
    tick();
    b_start = 0;
    n_checks++;
    if (b_flags !== 9'b00_000_0001) begin
      n_fails++;
      $display("[TB] FAIL reject_cols0 got %b expected 000000001", b_flags);
    end
    tick();
    n_checks++;
    if (b_flags !== 9'b0) begin
      n_fails++;
      $display("[TB] FAIL reject_cols0_after got %b expected 000000000", b_flags);
    end
    b_rows = 5; b_cols = 4; b_start = 1;
    tick();
    b_start = 0;
    n_checks++;
    if (b_flags !== 9'b00_000_0001) begin
      n_fails++;
      $display("[TB] FAIL reject_oversize got %b expected 000000001", b_flags);
    end
    tick();
    n_checks++;
    if (b_flags !== 9'b0) begin
      n_fails++;
      $display("[TB] FAIL reject_oversize_after got %b expected 000000000", b_flags);
    end
    // 4x4 exactly fills the 16-entry buffer and must be accepted.
    b_rows = 4; b_cols = 4; b_start = 1;
    tick();
    b_start = 0;
    n_checks++;
    if (b_flags !== 9'b11_000_0010 || b_mat_rd_addr !== 4'd0) begin
      n_fails++;
      $display("[TB] FAIL accept_full got flags=%b mat=%0d expected 110000010 mat=0", b_flags, b_mat_rd_addr);
    end
    b_abort = 1;
    tick();
    b_abort = 0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (b_flags !== 9'b0) begin
        n_fails++;
        $display("[TB] FAIL abort_b_flush cycle %0d got %b expected 000000000", k, b_flags);
      end
      tick();
    end
  endtask

  task automatic test_abort();
    bit seen;
    a_rows = 3; a_cols = 4; a_ready = 1; a_start = 1;
    tick();
    a_start = 0;
    for (int k = 0; k < 7; k++) tick();
    n_checks++;
    if (a_mat_rd_addr !== 10'd5 || a_vec_rd_addr !== 10'd1 || a_mat_rd_en !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL abort_point got mat=%0d vec=%0d en=%b expected mat=5 vec=1 en=1",
               a_mat_rd_addr, a_vec_rd_addr, a_mat_rd_en);
    end
    a_abort = 1;
    tick();
    a_abort = 0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (a_flags !== 9'b0) begin
        n_fails++;
        $display("[TB] FAIL abort_idle cycle %0d got %b expected 000000000", k, a_flags);
      end
      tick();
    end
    // Start and abort together in IDLE: start wins.
    a_rows = 1; a_cols = 2; a_start = 1; a_abort = 1;
    tick();
    a_start = 0; a_abort = 0;
    n_checks++;
    if (a_flags !== 9'b11_000_0010 || a_mat_rd_addr !== 10'd0 || a_vec_rd_addr !== 10'd0) begin
      n_fails++;
      $display("[TB] FAIL restart got flags=%b mat=%0d vec=%0d expected 110000010 mat=0 vec=0",
               a_flags, a_mat_rd_addr, a_vec_rd_addr);
    end
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (a_done) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_fails++;
      $display("[TB] FAIL restart_done got done=0 within 10 cycles expected done=1");
    end
    a_ready = 0;
    tick();
  endtask

  task automatic test_latency();
    exp_lat = '{9'b11_000_0010, 9'b00_000_0010, 9'b00_000_0010,
                9'b00_111_0010, 9'b00_000_1010, 9'b00_000_0100};
    b_rows = 1; b_cols = 1; b_ready = 1; b_start = 1;
    tick();
    b_start = 0;
    for (int k = 1; k <= 6; k++) begin
      n_checks++;
      if (b_flags !== exp_lat[k]) begin
        n_fails++;
        $display("[TB] FAIL latency cycle %0d got %b expected %b", k, b_flags, exp_lat[k]);
      end
      tick();
    end
    b_ready = 0;
  endtask

  task automatic test_back_to_back();
    a_rows = 2; a_cols = 2; a_ready = 1; a_start = 1;
    tick();
    a_start = 0;
    tick();
    a_rows = 1; a_cols = 3; a_start = 1;
    tick();
    a_start = 0;
    n_checks++;
    if (a_flags !== 9'b00_101_0010) begin
      n_fails++;
      $display("[TB] FAIL busy_start_c3 got %b expected 001010010", a_flags);
    end
    tick();
    n_checks++;
    if (a_flags !== 9'b00_000_1010 || a_res_row !== 8'd0) begin
      n_fails++;
      $display("[TB] FAIL busy_start_c4 got flags=%b row=%0d expected 000001010 row=0", a_flags, a_res_row);
    end
    tick();
    n_checks++;
    if (a_flags !== 9'b11_000_0010 || a_mat_rd_addr !== 10'd2) begin
      n_fails++;
      $display("[TB] FAIL busy_start_c5 got flags=%b mat=%0d expected 110000010 mat=2", a_flags, a_mat_rd_addr);
    end
    tick();
    n_checks++;
    if (a_flags !== 9'b11_110_0010 || a_mat_rd_addr !== 10'd3) begin
      n_fails++;
      $display("[TB] FAIL busy_start_c6 got flags=%b mat=%0d expected 111100010 mat=3", a_flags, a_mat_rd_addr);
    end
    tick();
    n_checks++;
    if (a_flags !== 9'b00_101_0010) begin
      n_fails++;
      $display("[TB] FAIL busy_start_c7 got %b expected 001010010", a_flags);
    end
    tick();
    n_checks++;
    if (a_flags !== 9'b00_000_1010 || a_res_row !== 8'd1) begin
      n_fails++;
      $display("[TB] FAIL busy_start_c8 got flags=%b row=%0d expected 000001010 row=1", a_flags, a_res_row);
    end
    tick();
    n_checks++;
    if (a_flags !== 9'b00_000_0100) begin
      n_fails++;
      $display("[TB] FAIL busy_start_done got %b expected 000000100", a_flags);
    end
    tick();
  endtask

  task automatic test_async_reset();
    a_rows = 1; a_cols = 4; a_ready = 1; a_start = 1;
    tick();
    a_start = 0;
    for (int k = 0; k < 4; k++) tick();
    n_checks++;
    if (a_flags !== 9'b00_101_0010) begin
      n_fails++;
      $display("[TB] FAIL drain_before_reset got %b expected 001010010", a_flags);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (a_flags !== 9'b0 || a_res_row !== 8'd0 || a_mat_rd_addr !== 10'd0) begin
      n_fails++;
      $display("[TB] FAIL async_reset got flags=%b row=%0d mat=%0d expected all 0",
               a_flags, a_res_row, a_mat_rd_addr);
    end
    #2 rst_n = 1'b1;
    a_ready = 0;
    tick();
    n_checks++;
    if (a_flags !== 9'b0) begin
      n_fails++;
      $display("[TB] FAIL after_reset got %b expected 000000000", a_flags);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_reject();
    test_abort();
    test_latency();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "[TB] watchdog");
  end

endmodule
